hash_index_feeder: RTL
======================

# hash_index_feeder

Upstream feeder for the cuckoo hashing stage. Buffers incoming 32-bit keys (transaction/block identifiers) in a small FIFO. For each key, computes the two candidate slot indices, one for table1 and one for table2, and presents key plus indices to the insertion stage over a valid/ready handshake. Decouples bursty key producers from the multi-cycle insert/evict behaviour of the hash tables.

## Interface
Parameters:
- TABLE_SIZE, 20: number of slots per table; indices range 0..TABLE_SIZE-1
- IDX_W, 5: index width; must satisfy 2^IDX_W >= TABLE_SIZE
- DEPTH, 8: FIFO depth in keys; power of two, >= 2
- CNT_W, 16: width of the accepted-key counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a key on in_key
- in_key  in  32  key to insert
- in_ready  out  1  feeder can accept a key this cycle
- out_valid  out  1  out_key/out_i1/out_i2 are valid
- out_ready  in  1  insertion stage consumes the output this cycle
- out_key  out  32  key
- out_i1  out  IDX_W  table1 index
- out_i2  out  IDX_W  table2 index
- level  out  $clog2(DEPTH)+1  keys held in FIFO; excludes the output register
- accepted  out  CNT_W  total keys accepted since reset; wraps modulo 2^CNT_W

## Operation
- Reset (async assert, sync release) drives these values:
  - FIFO empty; level=0
  - in_ready=1
  - out_valid=0; out_key=0, out_i1=0, out_i2=0
  - accepted=0
- Accept: when in_valid && in_ready, write in_key at the FIFO write pointer and increment accepted.
- in_ready = (level < DEPTH), purely from registered state. It has no combinational dependence on out_ready.
- Index function, pure arithmetic on the unsigned 32-bit key:
  - h1 = key mod TABLE_SIZE
  - h2 = (key / TABLE_SIZE) mod TABLE_SIZE
  - if h2 == h1, then h2 = (h1 + 1) mod TABLE_SIZE, so the two candidates always differ
- Output register load rule: a load happens when the FIFO is not empty and the output register is free (out_valid==0, or out_valid && out_ready).
  - The head key is popped and the register is loaded with key, h1 and h2.
  - out_valid=1 after the load.
- If the output is consumed and the FIFO is empty, out_valid goes to 0. out_key/out_i1/out_i2 hold their last values.
- While out_valid && !out_ready, out_key, out_i1 and out_i2 are held stable.
- Key 0 gets no special treatment: it is passed through with indices 0/1.
- Pointers wrap modulo DEPTH. Full vs. empty is distinguished by level, not by pointer equality.

## Timing
- Latency into an empty, idle block: a key accepted at edge E is visible with out_valid=1 after edge E+1. Minimum latency is 2 edges.
- Throughput is 1 key/cycle sustained when out_ready is held at 1.
- Push and pop in the same cycle: level is unchanged.
- Push when full: impossible, because in_ready=0. If in_valid is asserted while full, the key is ignored and accepted does not change.
- Push into an empty FIFO while the output is free: the key still passes through the FIFO. The output is loaded at the next edge; there is no bypass.
- The index arithmetic sits between the FIFO read and the output register: one combinational mod stage. It must close timing at the target clock.
- Reset asserted mid-operation clears the FIFO, out_valid and accepted immediately. In-flight keys are discarded.
- accepted wraps from 2^CNT_W-1 to 0.

## Test plan
- Single key: push 70 into an idle block with out_ready=1. Required: out_valid after 2 edges, out_key=70, out_i1=10, out_i2=3. Then push 87. Required: out_i1=7, out_i2=4.
- Collision rule: push 21. Required: h1=1, h2=1 is adjusted, so out_i1=1, out_i2=2. Push 0. Required: out_i1=0, out_i2=1.
- Backpressure: hold out_ready=0 and push 9 keys. Required:
  - 1 key sits in the output register and level reaches 8
  - in_ready=0 and the 10th key is not accepted
  - after releasing out_ready, all 9 keys emerge in order and none are lost or duplicated
- Streaming: push 100 random keys with in_valid=out_ready=1 every cycle. Required: 1 output per cycle after fill; every output matches the mod formulas; accepted=100.
- Random handshake: toggle in_valid and out_ready randomly over 1000 keys. Required: output order equals input order, and out_* stay stable whenever out_valid && !out_ready.
- Reset mid-stream: assert rst_n=0 with level=5 and out_valid=1. Required: level=0, out_valid=0, accepted=0 and in_ready=1 immediately. After release, the block operates normally.

Source files
------------

// File: rtl/hash_index_feeder.sv
// rtl/hash_index_feeder.sv - key FIFO plus cuckoo index computation feeding the insert stage
module hash_index_feeder #(
    parameter int TABLE_SIZE = 20,
    parameter int IDX_W      = 5,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_key,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_key,
    output logic [IDX_W-1:0]           out_i1,
    output logic [IDX_W-1:0]           out_i2,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [31:0] TS = 32'(TABLE_SIZE);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] accepted_q;
    logic             out_valid_q;
    logic [31:0]      out_key_q;
    logic [IDX_W-1:0] out_i1_q, out_i2_q;

    logic             push, pop, out_free;
    logic [31:0]      head, quot;
    logic [IDX_W-1:0] h1, h2_raw, h1_inc, h2;

    // Ready depends only on the registered fill level, never on out_ready.
    assign in_ready = (level_q < LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;
    assign pop      = (level_q != '0) && out_free;

    // Single combinational mod stage between the FIFO head and the output register.
    assign head   = mem_q[rd_ptr_q];
    assign quot   = head / TS;
    assign h1     = IDX_W'(head % TS);
    assign h2_raw = IDX_W'(quot % TS);
    assign h1_inc = (h1 == IDX_W'(TABLE_SIZE - 1)) ? '0 : h1 + IDX_W'(1);
    assign h2     = (h2_raw == h1) ? h1_inc : h2_raw;

    // Fill level moves by push minus pop; simultaneous push and pop cancel.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Key storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_key;
        end
    end

    // Pointers, level and accepted-key counter; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            accepted_q <= '0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                accepted_q <= accepted_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Output register: load on pop, drop valid when consumed with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
            out_i1_q    <= '0;
            out_i2_q    <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_key_q   <= head;
            out_i1_q    <= h1;
            out_i2_q    <= h2;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign out_i1    = out_i1_q;
    assign out_i2    = out_i2_q;
    assign level     = level_q;
    assign accepted  = accepted_q;

endmodule
